// File: rtl/whack_pkg.sv
// Shared types and constants for the whack-a-mole round sequencer and its LFSR.
package whack_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    SHOW = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int DEF_NUM_MOLES = 8;
  localparam int DEF_MOLE_W    = $clog2(DEF_NUM_MOLES);
  localparam int DEF_SCORE_W   = 8;

  // Feedback taps for x^8 + x^6 + x^5 + x^4 + 1 (bits 7, 5, 4, 3).
  localparam int             LFSR_W        = 8;
  localparam logic [LFSR_W-1:0] LFSR_TAPS     = 8'b1011_1000;
  localparam logic [LFSR_W-1:0] LFSR_SEED_DEF = 8'hA5;

endpackage

// File: rtl/mole_lfsr.sv
// Free-running 8-bit Fibonacci LFSR; shifts every cycle, synchronous reset to seed.
module mole_lfsr
  import whack_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED  = LFSR_SEED_DEF,
  parameter int                OUT_W = DEF_MOLE_W
) (
  input  logic             clk,
  input  logic             rst,
  output logic [OUT_W-1:0] rand_o
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign rand_o = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/mole_round_sequencer.sv
// Game controller: sequences gap/show rounds, picks non-repeating moles,
// scores hits and misses, and stops play when the game timer expires.
module mole_round_sequencer
  import whack_pkg::*;
#(
  parameter int                NUM_MOLES  = DEF_NUM_MOLES,
  parameter int                ON_CYCLES  = 500000,
  parameter int                GAP_CYCLES = 200000,
  parameter int                SCORE_W    = DEF_SCORE_W,
  parameter logic [LFSR_W-1:0] LFSR_SEED  = LFSR_SEED_DEF,
  localparam int               MOLE_W     = (NUM_MOLES > 1) ? $clog2(NUM_MOLES) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 game_end_in,
  input  logic [NUM_MOLES-1:0] btn_pulse,
  output logic                 timer_start,
  output logic                 mole_valid,
  output logic [MOLE_W-1:0]    mole_idx,
  output logic                 hit_pulse,
  output logic                 miss_pulse,
  output logic [SCORE_W-1:0]   score,
  output logic                 playing
);

  localparam int CNT_MAX = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

  logic [MOLE_W-1:0] rand_bits;

  mole_lfsr #(
    .SEED  (LFSR_SEED),
    .OUT_W (MOLE_W)
  ) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .rand_o (rand_bits)
  );

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SCORE_W-1:0] score_q, score_d;
  // The displayed mole doubles as the previous-mole memory for the repeat check.
  logic [MOLE_W-1:0] prev_mole_q, prev_mole_d;
  logic              mole_valid_q, mole_valid_d;
  logic              timer_start_q, timer_start_d;
  logic              hit_q, hit_d;
  logic              miss_q, miss_d;
  logic              playing_q, playing_d;

  logic [MOLE_W-1:0] cand;
  logic [MOLE_W-1:0] pick;

  always_comb begin
    cand = MOLE_W'(int'(rand_bits) % NUM_MOLES);
    pick = cand;
    if (cand == prev_mole_q) begin
      pick = MOLE_W'((int'(cand) + 1) % NUM_MOLES);
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    score_d       = score_q;
    prev_mole_d   = prev_mole_q;
    mole_valid_d  = mole_valid_q;
    timer_start_d = 1'b0;
    hit_d         = 1'b0;
    miss_d        = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          score_d       = '0;
          timer_start_d = 1'b1;
          cnt_d         = GAP_LOAD;
          state_d       = GAP;
        end
      end
      GAP: begin
        if (game_end_in) begin
          mole_valid_d = 1'b0;
          state_d      = DONE;
        end else if (cnt_q == '0) begin
          prev_mole_d  = pick;
          mole_valid_d = 1'b1;
          cnt_d        = ON_LOAD;
          state_d      = SHOW;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      SHOW: begin
        if (game_end_in) begin
          mole_valid_d = 1'b0;
          state_d      = DONE;
        end else if (btn_pulse[prev_mole_q] || (|btn_pulse) || (cnt_q == '0)) begin
          // A correct bit wins even when wrong bits arrive in the same cycle.
          if (btn_pulse[prev_mole_q]) begin
            hit_d   = 1'b1;
            score_d = (score_q == '1) ? score_q : score_q + SCORE_W'(1);
          end else begin
            miss_d = 1'b1;
          end
          mole_valid_d = 1'b0;
          cnt_d        = GAP_LOAD;
          state_d      = GAP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        mole_valid_d = 1'b0;
        state_d      = IDLE;
      end
    endcase

    playing_d = (state_d == GAP) || (state_d == SHOW);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      score_q       <= '0;
      prev_mole_q   <= '0;
      mole_valid_q  <= 1'b0;
      timer_start_q <= 1'b0;
      hit_q         <= 1'b0;
      miss_q        <= 1'b0;
      playing_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      score_q       <= score_d;
      prev_mole_q   <= prev_mole_d;
      mole_valid_q  <= mole_valid_d;
      timer_start_q <= timer_start_d;
      hit_q         <= hit_d;
      miss_q        <= miss_d;
      playing_q     <= playing_d;
    end
  end

  assign timer_start = timer_start_q;
  assign mole_valid  = mole_valid_q;
  assign mole_idx    = prev_mole_q;
  assign hit_pulse   = hit_q;
  assign miss_pulse  = miss_q;
  assign score       = score_q;
  assign playing     = playing_q;

endmodule
